// File: rtl/audio_fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_fir_pkg : shared types, helpers and default taps for audio_fir_mac   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package audio_fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_t;

    localparam int c_DEF_TAPS = 10;

    // Symmetric low-pass prototype, Q1.15.
    localparam logic [15:0] c_DEF_COEF [c_DEF_TAPS] = '{
        16'h00F2, 16'h087E, 16'h21F7, 16'h4F40, 16'h76DF,
        16'h76DF, 16'h4F40, 16'h21F7, 16'h087E, 16'h00F2
    };

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic signed [15:0] def_coef(input int idx);
        logic signed [15:0] v;
        v = '0;
        if (idx >= 0 && idx < c_DEF_TAPS) begin
            v = $signed(c_DEF_COEF[idx]);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sample_ring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_sample_ring : TAPS-deep sample history with tap-relative read port     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fir_sample_ring #(
    parameter int DW   = 16,
    parameter int TAPS = 10,
    parameter int AW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_we,
    input  logic [DW-1:0]        i_wdata,
    input  logic                 i_adv,
    input  logic [AW-1:0]        i_tap,
    output logic signed [DW-1:0] o_rdata
);

    logic signed [DW-1:0] r_hist [TAPS];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        w_rd_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_hist[i] <= '0;
            end
            r_wptr <= '0;
        end else begin
            if (i_we) begin
                r_hist[r_wptr] <= $signed(i_wdata);
            end
            if (i_adv) begin
                r_wptr <= (r_wptr == AW'(TAPS - 1)) ? '0 : r_wptr + 1'b1;
            end
        end
    end

    // Modular arithmetic in AW bits still lands on the right slot after wrap.
    assign w_rd_idx = (i_tap > r_wptr) ? (r_wptr + AW'(TAPS) - i_tap)
                                       : (r_wptr - i_tap);
    assign o_rdata  = r_hist[w_rd_idx];

endmodule
`default_nettype wire

// File: rtl/audio_fir_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_fir_mac : single-multiplier FIR with rounding, saturation, handshake |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module audio_fir_mac
    import audio_fir_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int TAPS  = 10,
    parameter int SHIFT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic                     out_sat,
    input  logic                     coef_we,
    input  logic [clog2(TAPS)-1:0]   coef_addr,
    input  logic [CW-1:0]            coef_data,
    output logic                     coef_err
);

    localparam int c_AW    = clog2(TAPS);
    localparam int c_PW    = DW + CW;
    localparam int c_ACC_W = DW + CW + c_AW;
    localparam int c_RND_W = c_ACC_W + 1;

    localparam logic signed [c_RND_W-1:0] c_RND_HALF = c_RND_W'(1) << (SHIFT - 1);
    localparam logic signed [c_RND_W-1:0] c_OUT_MAX  =
        {{(c_RND_W - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [c_RND_W-1:0] c_OUT_MIN  =
        {{(c_RND_W - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    fir_state_t                 r_state;
    fir_state_t                 w_state_nxt;
    logic [c_AW-1:0]            r_k;
    logic signed [c_ACC_W-1:0]  r_acc;
    logic signed [CW-1:0]       r_coef [TAPS];
    logic [DW-1:0]              r_out_data;
    logic                       r_out_valid;
    logic                       r_out_sat;
    logic                       r_coef_err;

    logic                       w_idle;
    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_coef_ok;
    logic                       w_coef_bad;
    logic                       w_last_tap;
    logic                       w_out_take;
    logic signed [DW-1:0]       w_hist;
    logic signed [c_PW-1:0]     w_prod;
    logic signed [c_ACC_W-1:0]  w_acc_nxt;
    logic signed [c_RND_W-1:0]  w_rnd_sum;
    logic signed [c_RND_W-1:0]  w_rnd_shift;
    logic                       w_sat_hi;
    logic                       w_sat_lo;
    logic [DW-1:0]              w_rnd_data;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_in_ready = w_idle && !coef_we;
    assign w_accept   = in_valid && w_in_ready;
    assign w_coef_ok  = coef_we && w_idle && ({1'b0, coef_addr} < (c_AW + 1)'(TAPS));
    assign w_coef_bad = coef_we && !w_coef_ok;
    assign w_last_tap = (r_k == c_AW'(TAPS - 1));
    assign w_out_take = r_out_valid && out_ready;

    fir_sample_ring #(
        .DW   (DW),
        .TAPS (TAPS),
        .AW   (c_AW)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_accept),
        .i_wdata (in_data),
        .i_adv   ((r_state == ST_OUT) && w_out_take),
        .i_tap   (r_k),
        .o_rdata (w_hist)
    );

    assign w_prod    = r_coef[r_k] * w_hist;
    assign w_acc_nxt = r_acc + {{c_AW{w_prod[c_PW-1]}}, w_prod};

    // Round half up, then clamp into the signed output range.
    assign w_rnd_sum   = {r_acc[c_ACC_W-1], r_acc} + c_RND_HALF;
    assign w_rnd_shift = w_rnd_sum >>> SHIFT;
    assign w_sat_hi    = (w_rnd_shift > c_OUT_MAX);
    assign w_sat_lo    = (w_rnd_shift < c_OUT_MIN);
    assign w_rnd_data  = w_sat_hi ? {1'b0, {(DW - 1){1'b1}}} :
                         w_sat_lo ? {1'b1, {(DW - 1){1'b0}}} :
                         w_rnd_shift[DW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)   w_state_nxt = ST_MAC;
            ST_MAC:   if (w_last_tap) w_state_nxt = ST_ROUND;
            ST_ROUND: w_state_nxt = ST_OUT;
            ST_OUT:   if (w_out_take) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_k         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_coef_err  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= (TAPS == c_DEF_TAPS) ? CW'(def_coef(i)) : '0;
            end
        end else begin
            r_coef_err <= w_coef_bad;
            if (w_coef_ok) begin
                r_coef[coef_addr] <= $signed(coef_data);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                ST_MAC: begin
                    r_acc <= w_acc_nxt;
                    r_k   <= w_last_tap ? '0 : r_k + 1'b1;
                end
                ST_ROUND: begin
                    r_out_data  <= w_rnd_data;
                    r_out_sat   <= w_sat_hi || w_sat_lo;
                    r_out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (w_out_take) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign coef_err  = r_coef_err;

endmodule
`default_nettype wire

// File: tb/tb_audio_fir_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_audio_fir_mac : directed + random bench against a convolution model     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_audio_fir_mac;

    localparam int TAPS  = 10;
    localparam int SHIFT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        coef_err;

    int errors = 0;
    int checks = 0;

    int m_def [TAPS] = '{242, 2174, 8695, 20288, 30431, 30431, 20288, 8695, 2174, 242};
    int m_coef [TAPS];
    int m_hist [$];

    audio_fir_mac #(
        .DW    (16),
        .CW    (16),
        .TAPS  (TAPS),
        .SHIFT (SHIFT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_err  (coef_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < TAPS; i++) m_coef[i] = m_def[i];
    endfunction

    // y[n] = sum c[k]*x[n-k], round half up, clamp to 16-bit signed.
    function automatic void model_step(input int x, output int y, output bit s);
        longint acc;
        longint r;
        m_hist.push_front(x);
        if (m_hist.size() > TAPS) void'(m_hist.pop_back());
        acc = 0;
        for (int k = 0; k < m_hist.size(); k++) acc += longint'(m_coef[k]) * longint'(m_hist[k]);
        r = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        s = 1'b0;
        if (r > 32767)       begin r = 32767;  s = 1'b1; end
        else if (r < -32768) begin r = -32768; s = 1'b1; end
        y = int'(r);
    endfunction

    task automatic run_sample(input logic [15:0] x, input int hold, input bit inject);
        int          y;
        bit          s;
        int          cnt;
        logic [15:0] held;
        model_step(int'($signed(x)), y, s);
        cnt = 0;
        while (!in_ready && cnt < 50) begin @(negedge clk); cnt++; end
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            if (inject && cnt == 3) begin
                coef_we   = 1'b1;
                coef_addr = 4'd1;
                coef_data = 16'($urandom);
            end else if (inject && cnt == 4) begin
                check("coef_err_busy", coef_err, 1);
                coef_we = 1'b0;
            end else if (inject && cnt == 5) begin
                check("coef_err_pulse", coef_err, 0);
            end
            @(negedge clk);
            cnt++;
        end
        check("latency", cnt, TAPS + 1);
        check("out_data", $signed(out_data), y);
        check("out_sat", out_sat, s);
        if (hold > 0) begin
            out_ready = 1'b0;
            held = out_data;
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held);
                check("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("valid_clear", out_valid, 0);
        check("ready_after", in_ready, 1);
    endtask

    task automatic write_coef(input logic [3:0] addr, input logic [15:0] data, input bit exp_err);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        #1;
        check("coef_blocks_input", in_ready, 0);
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_err", coef_err, exp_err);
        @(negedge clk);
        check("coef_err_clear", coef_err, 0);
        if (!exp_err) m_coef[addr] = int'($signed(data));
    endtask

    initial begin
        logic seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_reset();
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_coef_err", coef_err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_sample(16'h7FFF, 0, 1'b0);
        repeat (9) run_sample(16'h0000, 0, 1'b0);

        repeat (10) run_sample(16'h7FFF, 0, 1'b0);
        repeat (10) run_sample(16'h8000, 0, 1'b0);

        run_sample(16'($urandom), 5, 1'b0);
        run_sample(16'($urandom), 0, 1'b0);

        // Abort mid-MAC: no result may appear, history and coefs reload.
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("abort_no_output", seen, 0);
        run_sample(16'h7FFF, 0, 1'b0);
        repeat (9) run_sample(16'h0000, 0, 1'b0);

        write_coef(4'd0, 16'h4000, 1'b0);
        write_coef(4'd12, 16'h1111, 1'b1);
        run_sample(16'h7FFF, 0, 1'b1);
        check("coef0_impulse", $signed(out_data), 16384);
        repeat (3) run_sample(16'h0000, 0, 1'b0);

        repeat (25) run_sample(16'($urandom), int'($urandom_range(0, 3)), 1'b0);

        for (int i = 0; i < TAPS; i++) write_coef(4'(i), 16'($urandom), 1'b0);
        repeat (12) run_sample(16'($urandom), int'($urandom_range(0, 2)), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
